smvm_stream: RTL and testbench

SMVM_STREAM -- requirements
Module: smvm_stream

---
 rtl/smvm_pkg.sv | 21 ++
 rtl/smvm_mwfifo.sv | 70 +++++++
 rtl/smvm_stream.sv | 201 ++++++++++++++++++++
 tb/tb_smvm_stream.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/smvm_pkg.sv
// Shared FSM encoding and width derivations for the streaming sparse
// matrix-vector multiplier.
package smvm_pkg;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_VEC_LOAD = 2'd1,
    S_MAT      = 2'd2,
    S_DRAIN    = 2'd3
  } state_t;

  // Row result width: full product plus headroom for 2**CW terms.
  function automatic int calc_aw(input int vw, input int cw);
    return 2 * vw + cw;
  endfunction

  function automatic int calc_pw(input int fd);
    return (fd > 1) ? $clog2(fd) : 1;
  endfunction

endpackage

// File: rtl/smvm_mwfifo.sv
// Result FIFO: accepts up to K sparse-enabled words per cycle (compacted in
// lane order) and presents its head through a registered output stage.
module smvm_mwfifo
  import smvm_pkg::*;
#(
  parameter int K  = 4,
  parameter int AW = 23,
  parameter int FD = 16,
  localparam int PW = calc_pw(FD)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [K-1:0]    wr_en,
  input  logic [K*AW-1:0] wr_data,
  input  logic [K-1:0]    wr_last,
  output logic [PW:0]     count,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [AW-1:0]   out_data,
  output logic            out_last
);

  logic [AW:0]   mem [FD];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_idx [K];
  logic [PW:0]   n_wr;
  logic          pop;

  // Each enabled lane lands at the write pointer plus the number of enabled lanes below it.
  always_comb begin
    n_wr = '0;
    for (int k = 0; k < K; k++) begin
      wr_idx[k] = wr_ptr + n_wr[PW-1:0];
      n_wr      = n_wr + {{PW{1'b0}}, wr_en[k]};
    end
  end

  assign pop = (count != '0) && (!out_valid || out_ready);

  always_ff @(posedge clk) begin
    for (int k = 0; k < K; k++) begin
      if (wr_en[k]) begin
        mem[wr_idx[k]] <= {wr_last[k], wr_data[k*AW +: AW]};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr + n_wr[PW-1:0];
      count  <= count + n_wr - {{PW{1'b0}}, pop};
      if (pop) begin
        rd_ptr                <= rd_ptr + PW'(1);
        out_valid             <= 1'b1;
        {out_last, out_data}  <= mem[rd_ptr];
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/smvm_stream.sv
// Streaming sparse matrix-vector multiply: loads a dense vector, then consumes
// K-lane nonzero beats and emits one signed dot product per matrix row.
module smvm_stream
  import smvm_pkg::*;
#(
  parameter int K  = 4,
  parameter int VW = 8,
  parameter int CW = 7,
  parameter int FD = 16,
  localparam int AW = calc_aw(VW, CW),
  localparam int NW = $clog2(K) + 1,
  localparam int PW = calc_pw(FD)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cfg_valid,
  input  logic [CW:0]     cfg_cols,
  input  logic            vec_valid,
  output logic            vec_ready,
  input  logic [VW-1:0]   vec_data,
  input  logic            nz_valid,
  output logic            nz_ready,
  input  logic [NW-1:0]   nz_cnt,
  input  logic [K*VW-1:0] nz_val,
  input  logic [K*CW-1:0] nz_col,
  input  logic [K-1:0]    nz_eor,
  input  logic            nz_last,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [AW-1:0]   out_data,
  output logic            out_last,
  output logic            err
);

  function automatic logic [2*VW-1:0] smul(input logic [VW-1:0] a, input logic [VW-1:0] b);
    logic [2*VW-1:0] ea;
    logic [2*VW-1:0] eb;
    ea = {{VW{a[VW-1]}}, a};
    eb = {{VW{b[VW-1]}}, b};
    return ea * eb;
  endfunction

  state_t          state;
  logic [CW:0]     cols;
  logic [CW:0]     vec_cnt;
  logic [VW-1:0]   vram [2**CW];

  logic [K-1:0]    lane_on, lane_in_rng, lane_eor, lane_last;
  logic            accept;
  int              used;

  logic            s0_v;
  logic [VW-1:0]   s0_val [K];
  logic [VW-1:0]   s0_vec [K];
  logic [K-1:0]    s0_act, s0_eor, s0_last;
  logic            s1_v;
  logic [2*VW-1:0] s1_prod [K];
  logic [K-1:0]    s1_eor, s1_last;
  logic [AW-1:0]   acc, run;

  logic [K-1:0]    fifo_wr_en, fifo_wr_last;
  logic [K*AW-1:0] fifo_wr_data;
  logic [PW:0]     fifo_count;

  // The final lane of an nz_last beat always closes the open row.
  always_comb begin
    for (int k = 0; k < K; k++) begin
      lane_on[k]     = (k < int'(nz_cnt));
      lane_in_rng[k] = ({1'b0, nz_col[k*CW +: CW]} < cols);
      lane_last[k]   = nz_last && (k == int'(nz_cnt) - 1);
      lane_eor[k]    = lane_on[k] && (nz_eor[k] || lane_last[k]);
    end
  end

  // Reserve room for beats already inside the pipeline before accepting more.
  always_comb begin
    used     = int'(fifo_count) + K * (int'(s0_v) + int'(s1_v));
    nz_ready = (state == S_MAT) && (used + 2 * K <= FD);
  end

  assign vec_ready = (state == S_VEC_LOAD);
  assign accept    = nz_valid && nz_ready;

  always_ff @(posedge clk) begin
    if (state == S_VEC_LOAD && vec_valid) begin
      vram[vec_cnt[CW-1:0]] <= vec_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      cols    <= '0;
      vec_cnt <= '0;
      err     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cfg_valid) begin
            cols    <= cfg_cols;
            vec_cnt <= '0;
            err     <= 1'b0;
            state   <= S_VEC_LOAD;
          end
        end
        S_VEC_LOAD: begin
          if (vec_valid) begin
            vec_cnt <= vec_cnt + {{CW{1'b0}}, 1'b1};
            if (vec_cnt == cols - {{CW{1'b0}}, 1'b1}) state <= S_MAT;
          end
        end
        S_MAT: begin
          if (accept) begin
            if (|(lane_on & ~lane_in_rng)) err <= 1'b1;
            if (nz_last) state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (!s0_v && !s1_v && fifo_count == '0 && !out_valid) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Stage 0 fetches vector operands; stage 1 registers the products.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s0_v    <= 1'b0;
      s1_v    <= 1'b0;
      s0_act  <= '0;
      s0_eor  <= '0;
      s0_last <= '0;
      s1_eor  <= '0;
      s1_last <= '0;
      acc     <= '0;
      for (int k = 0; k < K; k++) begin
        s0_val[k]  <= '0;
        s0_vec[k]  <= '0;
        s1_prod[k] <= '0;
      end
    end else begin
      s0_v <= accept;
      if (accept) begin
        s0_act  <= lane_on & lane_in_rng;
        s0_eor  <= lane_eor;
        s0_last <= lane_last;
        for (int k = 0; k < K; k++) begin
          s0_val[k] <= nz_val[k*VW +: VW];
          s0_vec[k] <= vram[nz_col[k*CW +: CW]];
        end
      end
      s1_v <= s0_v;
      if (s0_v) begin
        s1_eor  <= s0_eor;
        s1_last <= s0_last;
        for (int k = 0; k < K; k++) begin
          s1_prod[k] <= s0_act[k] ? smul(s0_val[k], s0_vec[k]) : '0;
        end
      end
      if (s1_v) acc <= run;
    end
  end

  // Segmented scan: run carries the open row; each closing lane emits and restarts it.
  always_comb begin
    run          = acc;
    fifo_wr_en   = '0;
    fifo_wr_last = '0;
    fifo_wr_data = '0;
    for (int k = 0; k < K; k++) begin
      run = run + {{CW{s1_prod[k][2*VW-1]}}, s1_prod[k]};
      if (s1_v && s1_eor[k]) begin
        fifo_wr_en[k]             = 1'b1;
        fifo_wr_last[k]           = s1_last[k];
        fifo_wr_data[k*AW +: AW]  = run;
        run                       = '0;
      end else begin
        fifo_wr_en[k] = 1'b0;
      end
    end
  end

  smvm_mwfifo #(
    .K  (K),
    .AW (AW),
    .FD (FD)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (fifo_wr_en),
    .wr_data   (fifo_wr_data),
    .wr_last   (fifo_wr_last),
    .count     (fifo_count),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last)
  );

endmodule

// File: tb/tb_smvm_stream.sv
// Directed self-checking bench for smvm_stream with K=4, VW=8, CW=7, FD=16.
module tb_smvm_stream;

  localparam int K  = 4;
  localparam int VW = 8;
  localparam int CW = 7;
  localparam int FD = 16;
  localparam int AW = 2 * VW + CW;
  localparam int NW = $clog2(K) + 1;

  logic            clk = 1'b0;
  logic            rst;
  logic            cfg_valid;
  logic [CW:0]     cfg_cols;
  logic            vec_valid;
  logic            vec_ready;
  logic [VW-1:0]   vec_data;
  logic            nz_valid;
  logic            nz_ready;
  logic [NW-1:0]   nz_cnt;
  logic [K*VW-1:0] nz_val;
  logic [K*CW-1:0] nz_col;
  logic [K-1:0]    nz_eor;
  logic            nz_last;
  logic            out_valid;
  logic            out_ready;
  logic [AW-1:0]   out_data;
  logic            out_last;
  logic            err;

  int          checks = 0;
  int          errors = 0;
  int          vec_mem [128];
  logic [AW:0] rxq [$];

  always #5 clk = ~clk;

  smvm_stream #(.K(K), .VW(VW), .CW(CW), .FD(FD)) dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_cols(cfg_cols),
    .vec_valid(vec_valid), .vec_ready(vec_ready), .vec_data(vec_data),
    .nz_valid(nz_valid), .nz_ready(nz_ready), .nz_cnt(nz_cnt),
    .nz_val(nz_val), .nz_col(nz_col), .nz_eor(nz_eor), .nz_last(nz_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .err(err)
  );

  // Words are taken on the negedge before the popping posedge.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) rxq.push_back({out_last, out_data});
  end

  initial begin
    #3000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input int ncols);
    int guard;
    repeat (3) tick();
    rxq.delete();
    cfg_cols  = (CW+1)'(ncols);
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
    guard = 0;
    while (!vec_ready && guard < 50) begin
      tick();
      guard++;
    end
    if (!vec_ready) begin
      checks++;
      errors++;
      $display("FAIL vec_ready_timeout got 0 want 1");
    end
    for (int i = 0; i < ncols; i++) begin
      vec_valid = 1'b1;
      vec_data  = VW'(vec_mem[i]);
      tick();
    end
    vec_valid = 1'b0;
  endtask

  task automatic send_beat(input int cnt, input int v0, input int v1, input int v2, input int v3,
                           input int c0, input int c1, input int c2, input int c3,
                           input logic [K-1:0] eor, input logic last);
    int guard;
    nz_cnt   = NW'(cnt);
    nz_val   = {VW'(v3), VW'(v2), VW'(v1), VW'(v0)};
    nz_col   = {CW'(c3), CW'(c2), CW'(c1), CW'(c0)};
    nz_eor   = eor;
    nz_last  = last;
    nz_valid = 1'b1;
    guard = 0;
    @(negedge clk);
    while (!nz_ready && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    if (!nz_ready) begin
      checks++;
      errors++;
      $display("FAIL nz_ready_timeout got 0 want 1");
    end else begin
      @(posedge clk);
    end
    #1;
    nz_valid = 1'b0;
  endtask

  task automatic wait_rx(input int n);
    int guard;
    guard = 0;
    while (rxq.size() < n && guard < 400) begin
      @(negedge clk);
      guard++;
    end
    repeat (6) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (vec_ready !== 1'b0) begin errors++; $display("FAIL reset_vec_ready got %b want 0", vec_ready); end
    checks++; if (nz_ready !== 1'b0)  begin errors++; $display("FAIL reset_nz_ready got %b want 0", nz_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (out_last !== 1'b0)  begin errors++; $display("FAIL reset_out_last got %b want 0", out_last); end
    checks++; if (err !== 1'b0)       begin errors++; $display("FAIL reset_err got %b want 0", err); end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int lat;
    logic seen;
    vec_mem[0] = 1; vec_mem[1] = 2; vec_mem[2] = 3; vec_mem[3] = 4;
    start_job(4);
    send_beat(4, 1, 1, 1, 1, 0, 1, 2, 3, 4'b1010, 1'b1);
    lat = 0;
    seen = 1'b0;
    while (!seen && lat < 10) begin
      @(negedge clk);
      lat++;
      seen = out_valid;
    end
    checks++; if (lat - 1 !== 3) begin errors++; $display("FAIL basic_latency got %0d want 3", lat - 1); end
    wait_rx(2);
    checks++; if (rxq.size() !== 2) begin errors++; $display("FAIL basic_count got %0d want 2", rxq.size()); end
    checks++; if (rxq[0] !== {1'b0, AW'(3)}) begin errors++; $display("FAIL basic_row0 got %h want %h", rxq[0], {1'b0, AW'(3)}); end
    checks++; if (rxq[1] !== {1'b1, AW'(7)}) begin errors++; $display("FAIL basic_row1 got %h want %h", rxq[1], {1'b1, AW'(7)}); end
  endtask

  task automatic test_span();
    vec_mem[0] = 1; vec_mem[1] = 2; vec_mem[2] = 3; vec_mem[3] = 4;
    start_job(4);
    send_beat(4, 2, 2, 2, 2, 0, 1, 2, 3, 4'b0000, 1'b0);
    send_beat(1, -1, 0, 0, 0, 0, 0, 0, 0, 4'b0001, 1'b1);
    wait_rx(1);
    checks++; if (rxq.size() !== 1) begin errors++; $display("FAIL span_count got %0d want 1", rxq.size()); end
    checks++; if (rxq[0] !== {1'b1, AW'(19)}) begin errors++; $display("FAIL span_row got %h want %h", rxq[0], {1'b1, AW'(19)}); end
  endtask

  task automatic test_force_close();
    vec_mem[0] = 1; vec_mem[1] = 2; vec_mem[2] = 3; vec_mem[3] = 4;
    start_job(4);
    send_beat(4, 0, 1, 1, 1, 0, 3, 2, 1, 4'b0011, 1'b0);
    send_beat(1, 2, 100, 100, 100, 0, 0, 0, 0, 4'b1110, 1'b1);
    wait_rx(3);
    checks++; if (rxq.size() !== 3) begin errors++; $display("FAIL force_count got %0d want 3", rxq.size()); end
    checks++; if (rxq[0] !== {1'b0, AW'(0)}) begin errors++; $display("FAIL force_empty_row got %h want %h", rxq[0], {1'b0, AW'(0)}); end
    checks++; if (rxq[1] !== {1'b0, AW'(4)}) begin errors++; $display("FAIL force_row1 got %h want %h", rxq[1], {1'b0, AW'(4)}); end
    checks++; if (rxq[2] !== {1'b1, AW'(7)}) begin errors++; $display("FAIL force_closed got %h want %h", rxq[2], {1'b1, AW'(7)}); end
  endtask

  task automatic test_backpressure();
    logic          saw_low;
    logic          have;
    logic [AW-1:0] held;
    int            unstable;
    logic [AW:0]   got;
    logic [AW:0]   exp;
    vec_mem[0] = 1; vec_mem[1] = 2; vec_mem[2] = 3; vec_mem[3] = 4;
    start_job(4);
    out_ready = 1'b0;
    saw_low   = 1'b0;
    have      = 1'b0;
    held      = '0;
    unstable  = 0;
    fork
      begin
        for (int b = 0; b < 6; b++) begin
          send_beat(4, 4*b+1, 4*b+2, 4*b+3, 4*b+4, 0, 0, 0, 0, 4'b1111, (b == 5));
        end
      end
      begin
        repeat (20) begin
          @(negedge clk);
          if (!nz_ready) saw_low = 1'b1;
          if (out_valid && !have) begin
            held = out_data;
            have = 1'b1;
          end else if (out_valid && out_data !== held) begin
            unstable++;
          end
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    wait_rx(24);
    checks++; if (saw_low !== 1'b1) begin errors++; $display("FAIL bp_ready_drop got %b want 1", saw_low); end
    checks++; if (held !== AW'(1)) begin errors++; $display("FAIL bp_held_head got %0d want 1", held); end
    checks++; if (unstable !== 0) begin errors++; $display("FAIL bp_stable got %0d changes want 0", unstable); end
    checks++; if (rxq.size() !== 24) begin errors++; $display("FAIL bp_count got %0d want 24", rxq.size()); end
    for (int i = 0; i < 24; i++) begin
      got = (i < rxq.size()) ? rxq[i] : 'x;
      exp = {(i == 23), AW'(i + 1)};
      checks++;
      if (got !== exp) begin errors++; $display("FAIL bp_word%0d got %h want %h", i, got, exp); end
    end
  endtask

  task automatic test_range_err();
    vec_mem[0] = 5; vec_mem[1] = 6;
    start_job(2);
    send_beat(2, 1, 1, 0, 0, 0, 3, 0, 0, 4'b0010, 1'b1);
    wait_rx(1);
    checks++; if (rxq.size() !== 1) begin errors++; $display("FAIL range_count got %0d want 1", rxq.size()); end
    checks++; if (rxq[0] !== {1'b1, AW'(5)}) begin errors++; $display("FAIL range_row got %h want %h", rxq[0], {1'b1, AW'(5)}); end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL range_err_set got %b want 1", err); end
    repeat (5) tick();
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL range_err_sticky got %b want 1", err); end
  endtask

  task automatic test_extreme();
    for (int i = 0; i < 128; i++) vec_mem[i] = -128;
    start_job(128);
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL extreme_err_cleared got %b want 0", err); end
    for (int b = 0; b < 32; b++) begin
      send_beat(4, -128, -128, -128, -128, 4*b, 4*b+1, 4*b+2, 4*b+3,
                (b == 31) ? 4'b1000 : 4'b0000, (b == 31));
    end
    wait_rx(1);
    checks++; if (rxq.size() !== 1) begin errors++; $display("FAIL extreme_count got %0d want 1", rxq.size()); end
    checks++; if (rxq[0] !== {1'b1, AW'(2097152)}) begin errors++; $display("FAIL extreme_sum got %h want %h", rxq[0], {1'b1, AW'(2097152)}); end
  endtask

  task automatic test_reset_mid();
    vec_mem[0] = 1; vec_mem[1] = 2; vec_mem[2] = 3; vec_mem[3] = 4;
    start_job(4);
    out_ready = 1'b0;
    send_beat(4, 1, 1, 1, 1, 0, 1, 2, 3, 4'b0001, 1'b0);
    repeat (5) @(negedge clk);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rstmid_pending got %b want 1", out_valid); end
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_out_valid got %b want 0", out_valid); end
    checks++; if (nz_ready !== 1'b0)  begin errors++; $display("FAIL rstmid_nz_ready got %b want 0", nz_ready); end
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    vec_mem[0] = 4; vec_mem[1] = 3; vec_mem[2] = 2; vec_mem[3] = 1;
    start_job(4);
    send_beat(4, 1, 1, 1, 1, 0, 1, 2, 3, 4'b1001, 1'b1);
    wait_rx(2);
    checks++; if (rxq.size() !== 2) begin errors++; $display("FAIL rstmid_count got %0d want 2", rxq.size()); end
    checks++; if (rxq[0] !== {1'b0, AW'(4)}) begin errors++; $display("FAIL rstmid_row0 got %h want %h", rxq[0], {1'b0, AW'(4)}); end
    checks++; if (rxq[1] !== {1'b1, AW'(6)}) begin errors++; $display("FAIL rstmid_row1 got %h want %h", rxq[1], {1'b1, AW'(6)}); end
  endtask

  initial begin
    rst       = 1'b1;
    cfg_valid = 1'b0;
    cfg_cols  = '0;
    vec_valid = 1'b0;
    vec_data  = '0;
    nz_valid  = 1'b0;
    nz_cnt    = '0;
    nz_val    = '0;
    nz_col    = '0;
    nz_eor    = '0;
    nz_last   = 1'b0;
    out_ready = 1'b1;
    test_reset();
    test_basic();
    test_span();
    test_force_close();
    test_backpressure();
    test_range_err();
    test_extreme();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
